pipe_stage_buf: RTL and testbench



---
 rtl/pipe_pkg.sv | 33 +++
 rtl/pipe_skid_slot.sv | 23 ++
 rtl/pipe_stage_buf.sv | 101 ++++++++++
 tb/tb_pipe_stage_buf.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared stage-boundary payload layouts and defaults for pipe_stage_buf instances.
// The $bits of each stage struct sets DATA_W for the boundary that carries it.
package pipe_pkg;

    localparam int STALL_CNT_W = 16;

    typedef struct packed {
        logic [31:0] target;
        logic [31:0] alures;
        logic [31:0] val_d;
        logic [4:0]  reg_d;
        logic [7:0]  op;
        logic [3:0]  icc;
        logic        reg_we;
        logic        mem_we;
        logic        icc_we;
        logic [11:0] rsvd;
    } ex_mem_t;

    typedef struct packed {
        logic [31:0] alures;
        logic [31:0] mem_rd;
        logic [4:0]  reg_d;
        logic        reg_we;
        logic [57:0] rsvd;
    } mem_wb_t;

    localparam int      EX_MEM_W   = $bits(ex_mem_t);
    localparam int      MEM_WB_W   = $bits(mem_wb_t);
    localparam ex_mem_t EX_MEM_NOP = '0;
    localparam mem_wb_t MEM_WB_NOP = '0;

endpackage

// File: rtl/pipe_skid_slot.sv
// One-entry skid register: payload plus valid flag. Zero added latency; clear beats load.
// No backpressure of its own; the owning stage decides when to load or clear.
module pipe_skid_slot #(
    parameter int DATA_W = 128
) (
    input  logic              clk,
    input  logic              load,
    input  logic              clear,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q,
    output logic              valid
);

    always_ff @(posedge clk) begin
        if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            q     <= d;
        end
    end

endmodule

// File: rtl/pipe_stage_buf.sv
// Pipeline stage register with valid/ready, flush, NOP bubbles and saturating stall counter.
// Latency 1 cycle; base mode in_ready = out_ready | ~out_valid, PIPE_STAGE_SKID_EN registers in_ready via a skid slot.
module pipe_stage_buf
    import pipe_pkg::*;
#(
    parameter int                 DATA_W    = EX_MEM_W,
    parameter logic [DATA_W-1:0]  NOP_VALUE = '0,
    parameter int                 CNT_W     = STALL_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic              main_valid;
    logic [DATA_W-1:0] main_data;
    logic [CNT_W-1:0]  stall_q;
    logic              stalled;

    assign out_valid = main_valid;
    assign out_data  = main_data;
    assign stall_cnt = stall_q;
    assign stalled   = main_valid & ~out_ready;

    // Flush deliberately does not touch the counter; only reset clears it.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q <= '0;
        end else if (stalled && (stall_q != CNT_MAX)) begin
            stall_q <= stall_q + CNT_ONE;
        end
    end

`ifdef PIPE_STAGE_SKID_EN

    logic              skid_valid;
    logic [DATA_W-1:0] skid_data;
    logic              advance;
    logic              skid_load;
    logic              skid_clear;

    // Main register may take a new beat whenever it is empty or draining.
    assign advance    = ~main_valid | out_ready;
    assign in_ready   = ~skid_valid;
    assign skid_load  = ~advance & in_valid & ~skid_valid & ~flush;
    assign skid_clear = reset | flush | (advance & skid_valid);

    pipe_skid_slot #(
        .DATA_W (DATA_W)
    ) u_skid (
        .clk   (clk),
        .load  (skid_load),
        .clear (skid_clear),
        .d     (in_data),
        .q     (skid_data),
        .valid (skid_valid)
    );

    // A held skid beat is older than anything upstream, so it drains first.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            main_valid <= 1'b0;
            main_data  <= NOP_VALUE;
        end else if (advance) begin
            if (skid_valid) begin
                main_valid <= 1'b1;
                main_data  <= skid_data;
            end else begin
                main_valid <= in_valid;
                main_data  <= in_valid ? in_data : NOP_VALUE;
            end
        end
    end

`else

    assign in_ready = out_ready | ~main_valid;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            main_valid <= 1'b0;
            main_data  <= NOP_VALUE;
        end else if (in_ready) begin
            main_valid <= in_valid;
            main_data  <= in_valid ? in_data : NOP_VALUE;
        end
    end

`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed bench for pipe_stage_buf; expected beats queued at issue, checked by a monitor.
module tb_pipe_stage_buf;

    localparam int             DW  = 16;
    localparam int             CW  = 4;
    localparam logic [DW-1:0]  NOP = 16'hBEEF;

`ifdef PIPE_STAGE_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [DW-1:0] out_data;
    logic [CW-1:0] stall_cnt;

    int            errors = 0;
    int            checks = 0;
    int            popped = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] mon_exp;

    always #5 clk = ~clk;

    pipe_stage_buf #(
        .DATA_W    (DW),
        .NOP_VALUE (NOP),
        .CNT_W     (CW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .stall_cnt (stall_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        flush    = 1'b0;
        in_valid = 1'b1;
        in_data  = 16'h00AB;
        out_ready = 1'b1;
        step();
        step();
        reset    = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        popped   = 0;
    endtask

    // Monitor: every output transfer must match the oldest queued beat; idle cycles must show NOP.
    always @(negedge clk) begin
        if (!reset) begin
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got %0h expected none", out_data);
                end else begin
                    mon_exp = exp_q.pop_front();
                    chk("beat_order", {16'h0, out_data}, {16'h0, mon_exp});
                    popped++;
                end
            end else if (out_valid !== 1'b1) begin
                chk("idle_nop", {16'h0, out_data}, {16'h0, NOP});
            end
        end
    end

    initial begin
        // Reset with a live upstream beat that must be discarded.
        reset    = 1'b1;
        in_valid = 1'b1;
        in_data  = 16'h00AB;
        out_ready = 1'b1;
        step();
        @(negedge clk);
        chk("rst_in_valid_out", {31'h0, out_valid}, 0);
        chk("rst_in_data_out", {16'h0, out_data}, {16'h0, NOP});
        step();
        reset    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", {31'h0, out_valid}, 0);
        chk("rst_out_data", {16'h0, out_data}, {16'h0, NOP});
        chk("rst_stall_cnt", {28'h0, stall_cnt}, 0);
        chk("rst_in_ready", {31'h0, in_ready}, 1);

        // Streaming 1,2,3 back to back.
        do_reset();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 16'd1;
        exp_q.push_back(16'd1);
        for (int i = 1; i <= 3; i++) begin
            step();
            if (i < 3) begin
                in_data = DW'(i + 1);
                exp_q.push_back(DW'(i + 1));
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            chk("stream_valid", {31'h0, out_valid}, 1);
        end
        step();
        step();
        @(negedge clk);
        chk("stream_count", popped, 3);

        // Back-pressure: hold 5, present 6 during a 4-cycle stall.
        do_reset();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 16'd5;
        exp_q.push_back(16'd5);
        step();
        out_ready = 1'b0;
        in_data   = 16'd6;
        if (SKID) exp_q.push_back(16'd6);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("bp_hold_data", {16'h0, out_data}, 5);
            chk("bp_in_ready", {31'h0, in_ready}, (SKID && k == 0) ? 1 : 0);
            step();
        end
        out_ready = 1'b1;
        if (SKID) begin
            in_valid = 1'b0;
        end else begin
            exp_q.push_back(16'd6);
        end
        @(negedge clk);
        chk("bp_stall_cnt", {28'h0, stall_cnt}, 4);
        step();
        in_valid = 1'b0;
        step();
        step();
        @(negedge clk);
        chk("bp_count", popped, 2);
        chk("bp_stall_after", {28'h0, stall_cnt}, 4);

        // Flush collides with an incoming beat while 7 is stalled.
        do_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'd7;
        step();
        flush   = 1'b1;
        in_data = 16'd8;
        @(negedge clk);
        chk("fl_in_ready", {31'h0, in_ready}, SKID ? 1 : 0);
        step();
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("fl_valid", {31'h0, out_valid}, 0);
        chk("fl_data", {16'h0, out_data}, {16'h0, NOP});
        chk("fl_stall_cnt", {28'h0, stall_cnt}, 1);
        step();
        step();
        step();
        @(negedge clk);
        chk("fl_no_beats", popped, 0);

        // Saturation at 15 with CNT_W=4, survives flush, cleared by reset.
        do_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'd10;
        step();
        in_valid = 1'b0;
        repeat (20) step();
        @(negedge clk);
        chk("sat_value", {28'h0, stall_cnt}, 15);
        step();
        @(negedge clk);
        chk("sat_hold", {28'h0, stall_cnt}, 15);
        chk("sat_data", {16'h0, out_data}, 10);
        flush = 1'b1;
        step();
        flush = 1'b0;
        @(negedge clk);
        chk("sat_after_flush", {28'h0, stall_cnt}, 15);
        chk("sat_flush_valid", {31'h0, out_valid}, 0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clk);
        chk("sat_after_reset", {28'h0, stall_cnt}, 0);

        // Bubble after beat 9.
        do_reset();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 16'd9;
        exp_q.push_back(16'd9);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        chk("bub_beat_valid", {31'h0, out_valid}, 1);
        chk("bub_beat_data", {16'h0, out_data}, 9);
        step();
        @(negedge clk);
        chk("bub_valid", {31'h0, out_valid}, 0);
        chk("bub_data", {16'h0, out_data}, {16'h0, NOP});

        chk("leftover_beats", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
